// File: rtl/exc_ctrl.sv
// exc_ctrl -- exception / interrupt redirect controller for the 5-stage pipeline.
//
// Detects an undefined opcode in ID (illop) or a pending interrupt. It waits
// until the ID-stage instruction is neither stalled nor an uncommitted
// branch/jump. It then spends exactly one cycle in REDIRECT, where it:
//   - overrides the PC select,
//   - flushes IF/ID and ID/EX,
//   - writes the return address into $26.
// It stays in KERNEL until the fetch PC leaves kernel space again.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   pc_if      current fetch PC, bit 31 = kernel-mode flag
//   id_pc      PC of the instruction in ID
//   irq_req    level interrupt request
//   illop      ID instruction has an undefined opcode
//   id_is_bj   ID instruction is a branch/jump (target not yet committed)
//   stall      pipeline hold (load-use hazard)
//   exc_pcsrc  PC select override: 000 none, 100 ILLOP vector, 101 XADR vector
//   exc_flush  flush IF/ID and ID/EX
//   epc        return address for $26
//   epc_we     write enable for $26
//   irq_ack    one-cycle acknowledge to the interrupt source
//   kernel     controller is in REDIRECT or KERNEL
//   exc_count  saturating count of exceptions taken

module exc_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_if,
  input  logic [31:0] id_pc,
  input  logic        irq_req,
  input  logic        illop,
  input  logic        id_is_bj,
  input  logic        stall,
  output logic [2:0]  exc_pcsrc,
  output logic        exc_flush,
  output logic [31:0] epc,
  output logic        epc_we,
  output logic        irq_ack,
  output logic        kernel,
  output logic [7:0]  exc_count
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_KERNEL   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        pending;
  logic        cause_irq;
  logic        irq_eligible;
  logic        event_eligible;
  logic        blocked;
  logic        enter_redirect;
  logic [31:0] illop_pc;

  // A request sampled on this very edge counts too. Without that, an IRQ would
  // not reach REDIRECT in the cycle right after it is first seen.
  assign irq_eligible   = (pending | irq_req) & ~pc_if[31];
  assign event_eligible = illop | irq_eligible;
  assign blocked        = stall | id_is_bj;
  assign illop_pc       = id_pc + 32'd4;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (event_eligible) begin
          state_next = blocked ? ST_WAIT : ST_REDIRECT;
        end
      end
      ST_WAIT: begin
        if (!blocked) begin
          state_next = ST_REDIRECT;
        end
      end
      ST_REDIRECT: state_next = ST_KERNEL;
      ST_KERNEL: begin
        if (!pc_if[31]) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign enter_redirect = (state_next == ST_REDIRECT) && (state != ST_REDIRECT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      pending   <= 1'b0;
      cause_irq <= 1'b0;
      epc       <= 32'd0;
      exc_count <= 8'd0;
    end else begin
      state <= state_next;

      // The acknowledge clears the latch. This takes priority over a set,
      // because the source still holds irq_req on the edge where it sees
      // irq_ack.
      if (state == ST_REDIRECT && cause_irq) begin
        pending <= 1'b0;
      end else if (irq_req) begin
        pending <= 1'b1;
      end

      // illop wins the cause. A simultaneous interrupt stays in the latch.
      if (enter_redirect) begin
        cause_irq <= ~illop;
        epc       <= illop ? {1'b0, illop_pc[30:0]} : {1'b0, id_pc[30:0]};
        if (exc_count != 8'hFF) begin
          exc_count <= exc_count + 8'd1;
        end
      end
    end
  end

  // Outputs decode straight from the state flops. A reset therefore clears
  // them at once, even in the middle of REDIRECT.
  assign exc_pcsrc = (state == ST_REDIRECT) ? {2'b10, cause_irq} : 3'b000;
  assign exc_flush = (state == ST_REDIRECT);
  assign epc_we    = (state == ST_REDIRECT);
  assign irq_ack   = (state == ST_REDIRECT) && cause_irq;
  assign kernel    = (state == ST_REDIRECT) || (state == ST_KERNEL);

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl -- self-checking bench for exc_ctrl.
//
// A flag-based reference model tracks what the controller should be doing:
//   - waiting for the pipeline,
//   - redirecting,
//   - in kernel,
//   - holding a pending interrupt.
// The model is updated on every rising edge.
//
// Outputs are compared on the falling edge. Directed scenarios are followed by
// randomized traffic and a saturation run.

module tb_exc_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc_if;
  logic [31:0] id_pc;
  logic        irq_req;
  logic        illop;
  logic        id_is_bj;
  logic        stall;
  logic [2:0]  exc_pcsrc;
  logic        exc_flush;
  logic [31:0] epc;
  logic        epc_we;
  logic        irq_ack;
  logic        kernel;
  logic [7:0]  exc_count;

  int tests;
  int failures;

  bit          m_pending;
  bit          m_waiting;
  bit          m_redirect;
  bit          m_kernel;
  bit          m_irq_cause;
  logic [31:0] m_epc;
  int          m_count;

  exc_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .pc_if     (pc_if),
    .id_pc     (id_pc),
    .irq_req   (irq_req),
    .illop     (illop),
    .id_is_bj  (id_is_bj),
    .stall     (stall),
    .exc_pcsrc (exc_pcsrc),
    .exc_flush (exc_flush),
    .epc       (epc),
    .epc_we    (epc_we),
    .irq_ack   (irq_ack),
    .kernel    (kernel),
    .exc_count (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic void model_reset();
    m_pending   = 0;
    m_waiting   = 0;
    m_redirect  = 0;
    m_kernel    = 0;
    m_irq_cause = 0;
    m_epc       = 32'd0;
    m_count     = 0;
  endfunction

  // One rising edge of the controller, phrased as the behaviour rules:
  // what the controller does next, given where it is and what it sees.
  function automatic void model_update();
    bit was_redirect_irq;
    bit take;
    was_redirect_irq = m_redirect && m_irq_cause;
    take = 0;
    if (m_redirect) begin
      m_redirect = 0;
      m_kernel   = 1;
    end else if (m_kernel) begin
      if (pc_if[31] == 1'b0) m_kernel = 0;
    end else if (m_waiting) begin
      if (!stall && !id_is_bj) take = 1;
    end else begin
      if (illop || ((m_pending || irq_req) && pc_if[31] == 1'b0)) begin
        if (stall || id_is_bj) m_waiting = 1;
        else take = 1;
      end
    end
    if (was_redirect_irq) m_pending = 0;
    else if (irq_req) m_pending = 1;
    if (take) begin
      m_waiting   = 0;
      m_redirect  = 1;
      m_irq_cause = !illop;
      m_epc       = illop ? ((id_pc + 32'd4) & 32'h7FFF_FFFF) : (id_pc & 32'h7FFF_FFFF);
      if (m_count < 255) m_count++;
    end
  endfunction

  task automatic check_all(input string tag);
    checkOutput({tag, ".pcsrc"}, {29'd0, exc_pcsrc},
                m_redirect ? (m_irq_cause ? 32'd5 : 32'd4) : 32'd0);
    checkOutput({tag, ".flush"}, {31'd0, exc_flush}, {31'd0, m_redirect});
    checkOutput({tag, ".epc_we"}, {31'd0, epc_we}, {31'd0, m_redirect});
    checkOutput({tag, ".ack"}, {31'd0, irq_ack}, {31'd0, m_redirect && m_irq_cause});
    checkOutput({tag, ".kernel"}, {31'd0, kernel}, {31'd0, m_redirect || m_kernel});
    checkOutput({tag, ".epc"}, epc, m_epc);
    checkOutput({tag, ".count"}, {24'd0, exc_count}, m_count);
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] idp,
                               input logic irq, input logic ill,
                               input logic bj, input logic st);
    pc_if    = pc;
    id_pc    = idp;
    irq_req  = irq;
    illop    = ill;
    id_is_bj = bj;
    stall    = st;
  endtask

  // Advance one clock: the model follows the same rising edge, then
  // everything is compared on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    if (reset) model_update();
    else model_reset();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    tests    = 0;
    failures = 0;
    model_reset();
    reset = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    checkOutput("reset.kernel0", {31'd0, kernel}, 32'd0);
    checkOutput("reset.count0", {24'd0, exc_count}, 32'd0);
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step("idle");

    // Single IRQ, no blocking.
    applyStimulus(32'h0000_0040, 32'h0000_003C, 1'b1, 1'b0, 1'b0, 1'b0);
    step("irq");
    checkOutput("irq.pcsrc101", {29'd0, exc_pcsrc}, 32'd5);
    checkOutput("irq.epc3c", epc, 32'h0000_003C);
    checkOutput("irq.ack1", {31'd0, irq_ack}, 32'd1);
    applyStimulus(32'h8000_0080, 32'h0000_0040, 1'b0, 1'b0, 1'b0, 1'b0);
    step("irq_k");
    checkOutput("irq.kernel1", {31'd0, kernel}, 32'd1);
    applyStimulus(32'h0000_003C, 32'h0000_0038, 1'b0, 1'b0, 1'b0, 1'b0);
    step("irq_ret");
    checkOutput("irq.kernel0", {31'd0, kernel}, 32'd0);

    // illop and IRQ together: illop first, IRQ after the return.
    applyStimulus(32'h0000_0104, 32'h0000_0100, 1'b1, 1'b1, 1'b0, 1'b0);
    step("both");
    checkOutput("both.pcsrc100", {29'd0, exc_pcsrc}, 32'd4);
    checkOutput("both.epc104", epc, 32'h0000_0104);
    checkOutput("both.ack0", {31'd0, irq_ack}, 32'd0);
    applyStimulus(32'h8000_0080, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b0);
    step("both_k");
    applyStimulus(32'h0000_0104, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step("both_ret");
    step("both_irq");
    checkOutput("both.irq101", {29'd0, exc_pcsrc}, 32'd5);
    applyStimulus(32'h8000_0080, 32'h0000_0104, 1'b0, 1'b0, 1'b0, 1'b0);
    step("both_k2");
    applyStimulus(32'h0000_0010, 32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b0);
    step("both_ret2");

    // Blocked by branch/jump twice, then a stall, then free.
    applyStimulus(32'h0000_0020, 32'h0000_001C, 1'b1, 1'b0, 1'b1, 1'b0);
    step("wait1");
    checkOutput("wait1.pcsrc0", {29'd0, exc_pcsrc}, 32'd0);
    applyStimulus(32'h0000_0020, 32'h0000_001C, 1'b0, 1'b0, 1'b1, 1'b0);
    step("wait2");
    applyStimulus(32'h0000_0020, 32'h0000_001C, 1'b0, 1'b0, 1'b0, 1'b1);
    step("wait3");
    checkOutput("wait3.pcsrc0", {29'd0, exc_pcsrc}, 32'd0);
    applyStimulus(32'h0000_0024, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wait_go");
    checkOutput("wait.pcsrc101", {29'd0, exc_pcsrc}, 32'd5);
    checkOutput("wait.epc20", epc, 32'h0000_0020);
    applyStimulus(32'h8000_0080, 32'h0000_0024, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wait_k");
    applyStimulus(32'h0000_0020, 32'h0000_001C, 1'b0, 1'b0, 1'b0, 1'b0);
    step("wait_ret");

    // Interrupt masked while the fetch PC is in kernel space.
    applyStimulus(32'h8000_0020, 32'h8000_001C, 1'b1, 1'b0, 1'b0, 1'b0);
    step("mask1");
    checkOutput("mask.pcsrc0", {29'd0, exc_pcsrc}, 32'd0);
    applyStimulus(32'h8000_0024, 32'h8000_0020, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mask2");
    applyStimulus(32'h0000_0200, 32'h8000_01FC, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mask_go");
    checkOutput("mask.pcsrc101", {29'd0, exc_pcsrc}, 32'd5);
    checkOutput("mask.epc1fc", epc, 32'h0000_01FC);
    applyStimulus(32'h8000_0080, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mask_k");
    applyStimulus(32'h0000_01FC, 32'h0000_01F8, 1'b0, 1'b0, 1'b0, 1'b0);
    step("mask_ret");

    // Randomized traffic. Kernel-space fetch PCs are likely while the model
    // is in kernel, and rare otherwise.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pc;
      logic [31:0] ip;
      pc = $urandom;
      ip = ($urandom_range(15) == 0) ? 32'hFFFF_FFFE : $urandom;
      if (m_kernel || m_redirect) pc[31] = ($urandom_range(3) != 0);
      else pc[31] = ($urandom_range(7) == 0);
      applyStimulus(pc, ip, ($urandom_range(9) == 0), ($urandom_range(11) == 0),
                    ($urandom_range(3) == 0), ($urandom_range(4) == 0));
      step("rand");
    end

    // Reset asserted in the middle of REDIRECT aborts everything at once.
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6 && (m_kernel || m_waiting || m_redirect); i++) step("drain");
    applyStimulus(32'h0000_0300, 32'h0000_02FC, 1'b0, 1'b1, 1'b0, 1'b0);
    step("rst_pre");
    checkOutput("rst_pre.pcsrc100", {29'd0, exc_pcsrc}, 32'd4);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    checkOutput("rst_mid.we0", {31'd0, epc_we}, 32'd0);
    checkOutput("rst_mid.count0", {24'd0, exc_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step("rst_after");

    // Back-to-back illegal opcodes: the count climbs and then saturates.
    applyStimulus(32'h0000_0000, 32'h0000_0400, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3 * 262; i++) step("sat");
    checkOutput("sat.countff", {24'd0, exc_count}, 32'h0000_00FF);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
